// File: rtl/twiddle_gen.sv
// rtl/twiddle_gen.sv - sequenced quarter-wave twiddle-factor generator for radix-2 MDC FFT (option: TWGEN_INVERSE_EN)
module twiddle_gen #(
  parameter int N_FFT = 32,
  parameter int W_W   = 9,
  parameter int STG_W = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [STG_W-1:0]         stage,
  input  logic                     cont,
  input  logic                     adv,
`ifdef TWGEN_INVERSE_EN
  input  logic                     inv,
`endif
  output logic signed [W_W-1:0]    w_r,
  output logic signed [W_W-1:0]    w_i,
  output logic [$clog2(N_FFT)-2:0] w_idx,
  output logic                     w_valid,
  output logic                     w_last,
  output logic                     busy
);

  localparam int LOG2N = $clog2(N_FFT);
  localparam int IW    = LOG2N - 1;
  localparam int Q     = N_FFT / 4;
  localparam int S     = 2 ** (W_W - 2);
  localparam real PI   = 3.14159265358979323846;
  localparam logic [STG_W-1:0] S_MAX = STG_W'(LOG2N - 1);
  localparam logic [IW-1:0]    K_ALL = '1;

  // Quarter-wave cosine sample, truncated toward zero, evaluated at elaboration only
  function automatic int cos_entry(input int j);
    real v;
    v = real'(S) * $cos(2.0 * PI * real'(j) / real'(N_FFT));
    return $rtoi(v);
  endfunction

  logic signed [W_W-1:0] ctab [Q+1];

  for (genvar g = 0; g <= Q; g++) begin : g_ctab
    localparam int CV = cos_entry(g);
    assign ctab[g] = W_W'(CV);
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q;
  logic [STG_W-1:0]      stage_q;
  logic                  cont_q;
  logic [IW-1:0]         k_q;
  logic signed [W_W-1:0] w_r_q, w_i_q;
  logic [IW-1:0]         w_idx_q;
  logic                  w_valid_q, w_last_q;
`ifdef TWGEN_INVERSE_EN
  logic                  inv_q;
`endif

  logic [STG_W-1:0]      stage_d;
  logic [IW-1:0]         m_d, p_d, qmp_d, lmax_d;
  logic                  last_d;
  logic signed [W_W-1:0] wr_d, wi_d;

  // Index m = k<<s, end-of-pass detection and two-quadrant fold of the cosine table
  always_comb begin
    stage_d = (stage > S_MAX) ? S_MAX : stage;
    m_d     = k_q << stage_q;
    lmax_d  = K_ALL >> stage_q;
    last_d  = (k_q == lmax_d);
    p_d     = {1'b0, m_d[IW-2:0]};
    qmp_d   = IW'(Q) - p_d;
    if (!m_d[IW-1]) begin
      wr_d = ctab[p_d];
      wi_d = -ctab[qmp_d];
    end else begin
      wr_d = -ctab[qmp_d];
      wi_d = -ctab[p_d];
    end
  end

  // Sequencer: start reloads configuration, adv in RUN issues one registered twiddle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      stage_q   <= '0;
      cont_q    <= 1'b0;
      k_q       <= '0;
      w_r_q     <= '0;
      w_i_q     <= '0;
      w_idx_q   <= '0;
      w_valid_q <= 1'b0;
      w_last_q  <= 1'b0;
`ifdef TWGEN_INVERSE_EN
      inv_q     <= 1'b0;
`endif
    end else begin
      w_valid_q <= 1'b0;
      w_last_q  <= 1'b0;
      if (start) begin
        state_q <= RUN;
        stage_q <= stage_d;
        cont_q  <= cont;
        k_q     <= '0;
`ifdef TWGEN_INVERSE_EN
        inv_q   <= inv;
`endif
      end else if (state_q == RUN && adv) begin
        w_r_q     <= wr_d;
`ifdef TWGEN_INVERSE_EN
        w_i_q     <= inv_q ? -wi_d : wi_d;
`else
        w_i_q     <= wi_d;
`endif
        w_idx_q   <= m_d;
        w_valid_q <= 1'b1;
        w_last_q  <= last_d;
        if (last_d) begin
          k_q <= '0;
          if (!cont_q) state_q <= IDLE;
        end else begin
          k_q <= k_q + IW'(1);
        end
      end
    end
  end

  assign w_r     = w_r_q;
  assign w_i     = w_i_q;
  assign w_idx   = w_idx_q;
  assign w_valid = w_valid_q;
  assign w_last  = w_last_q;
  assign busy    = (state_q == RUN);

endmodule
